store_narrower: RTL and testbench
=================================

Name: store_narrower

Overview:
- Store-side data path for the single-cycle CPU with jump. It is the inverse of load-side sign extension.
- Accepts a 32-bit store request of byte, halfword or word size from the datapath. Narrows it onto a 16-bit data-memory write port over one or two handshaked beats, with byte enables.
- Flags values that cannot be reproduced by sign-extending the stored bits.
- Sits between the ALU/register-file outputs and the narrow data memory.

Parameters:
- ADDR_WIDTH, 32, width of request and memory byte addresses.
- DUP_BYTE, 1, when 1 a byte store drives the byte on both data lanes; when 0 the unused lane is driven 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  store request valid
- req_ready_o  out  1  block can accept a request; high only in IDLE
- addr_i  in  ADDR_WIDTH  byte address
- data_i  in  32  store data, right-justified
- size_i  in  2  store size: 00 byte, 01 half, 10 word, 11 reserved
- mem_valid_o  out  1  memory write beat valid
- mem_ready_i  in  1  memory accepts beat
- mem_addr_o  out  ADDR_WIDTH  beat address, even-aligned
- mem_data_o  out  16  beat data
- mem_be_o  out  2  byte enables; bit0 is the low byte
- done_o  out  1  one-cycle pulse: request finished, or rejected
- err_o  out  1  one-cycle pulse: misaligned or reserved-size request rejected
- ovf_o  out  1  one-cycle pulse with done_o: truncation lost information

Behaviour:
- Reset values (synchronous, rst_i high at a clk_i edge): state IDLE; mem_valid_o, done_o, err_o and ovf_o 0; mem_addr_o, mem_data_o and mem_be_o 0. req_ready_o is 1 as soon as IDLE is entered.
- Request acceptance: a request is accepted on an edge where req_valid_i && req_ready_o. On acceptance, addr_i, data_i and size_i are captured.
- Rejected requests: a request is rejected if any of the following holds:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]!=00.
- On rejection: return to IDLE with no memory beat. done_o and err_o pulse in the next cycle.
- Overflow flag, computed on capture:
  - byte: ovf = data[31:7] is not all-equal;
  - half: ovf = data[31:15] is not all-equal;
  - word: ovf = 0.
- ovf is reported on ovf_o together with done_o. The store still proceeds, since truncation is architecturally legal.
- States and transitions:
  - IDLE -> BEAT_LO on a legal accept.
  - BEAT_LO -> BEAT_HI when mem_valid_o && mem_ready_i and size is word.
  - BEAT_LO -> FIN when mem_valid_o && mem_ready_i and size is byte or half.
  - BEAT_HI -> FIN when mem_valid_o && mem_ready_i.
  - FIN -> IDLE unconditionally. done_o is high in FIN and low everywhere else.
- BEAT_LO outputs:
  - mem_addr_o = {addr[ADDR_WIDTH-1:1],0}.
  - byte: mem_data_o = {b,b} with DUP_BYTE=1, otherwise the byte in its lane; mem_be_o = addr[0] ? 10 : 01.
  - half: mem_data_o = data[15:0]; mem_be_o = 11.
  - word: mem_data_o = data[15:0]; mem_be_o = 11.
- BEAT_HI outputs: mem_addr_o = addr+2; mem_data_o = data[31:16]; mem_be_o = 11. The memory is little-endian.
- Beat handshake: mem_valid_o is high throughout BEAT_LO and BEAT_HI. mem_addr_o, mem_data_o and mem_be_o are stable while mem_valid_o && !mem_ready_i. The outputs are registered, so no combinational path runs from mem_ready_i to mem_valid_o.
- Latency with mem_ready_i tied high:
  - byte/half: accept at edge N; beat in cycle N+1; done in cycle N+2; req_ready_o high in N+3.
  - word: done in cycle N+3; req_ready_o high in N+4.
- Backpressure: each cycle mem_ready_i is low adds one cycle to the latency. Unbounded stall is permitted.
- Address wrap: addr+2 wraps modulo 2^ADDR_WIDTH.
- Reset mid-operation: the beat is aborted immediately and mem_valid_o drops at that edge. No done_o pulse is produced. A word interrupted after BEAT_LO leaves only its low half written. Software must not rely on atomicity.
- Request signals are ignored whenever req_ready_o is 0.

Decomposition:
- Shared package holds:
  - the size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the FSM state encodings (IDLE, BEAT_LO, BEAT_HI, FIN);
  - MEM_WIDTH=16.
- One natural sub-module, narrow_check. It is combinational and produces the misalign/reserved error and the ovf flag from size, addr[1:0] and data. It is reusable by the load path for alignment checks.

Test Plan:
- Byte store: size=00, addr=0x1001, data=0x0000_0080 -> one beat, addr 0x1000, be=10, data 0x8080, ovf=1 at done; without stall, done in cycle N+2.
- Half store: size=01, addr=0x2002, data=0xFFFF_8001 -> one beat, addr 0x2002, be=11, data 0x8001, ovf=0, err=0.
- Word store with mem_ready_i low for 3 cycles on BEAT_LO: data=0xDEAD_BEEF, addr=0x3000 -> beat 0x3000/0xBEEF held stable for 4 cycles, then 0x3002/0xDEAD, then done.
- Misaligned: word at 0x4002, then half at 0x4001, then size=11 -> no mem_valid_o, err_o and done_o pulse the cycle after each accept.
- Wrap: word at 0xFFFF_FFFC -> beats at 0xFFFF_FFFC and 0xFFFF_FFFE. A word at 0xFFFF_FFFE is rejected as misaligned.
- Reset asserted during BEAT_HI stall -> mem_valid_o 0 and req_ready_o 1 the next cycle, no done_o; a subsequent byte store completes normally.

Source files
------------

// File: rtl/store_narrower_pkg.sv
// rtl/store_narrower_pkg.sv - shared encodings for the store narrowing path
// Purpose: store size codes, FSM state codes and memory port width.
package store_narrower_pkg;

   localparam int MEM_WIDTH = 16;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      BEAT_LO = 2'b01,
      BEAT_HI = 2'b10,
      FIN     = 2'b11
   } state_e;

endpackage

// File: rtl/store_narrower_narrow_check.sv
// rtl/store_narrower_narrow_check.sv - alignment and truncation check for a memory access
// Purpose: combinational misalign/reserved-size error and truncation flag.
// Ports:
//   size    in  2   access size code
//   addr_lo in  2   low two address bits
//   data    in  32  right-justified store data
//   err     out 1   reserved size or misaligned access
//   ovf     out 1   value not reproducible by sign-extending the stored bits
module narrow_check
   import store_narrower_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] data,
   output logic        err,
   output logic        ovf
);

   always_comb begin
      err = 1'b0;
      ovf = 1'b0;
      case (size)
         SZ_BYTE: ovf = !((&data[31:7]) || !(|data[31:7]));
         SZ_HALF: begin
            err = addr_lo[0];
            ovf = !((&data[31:15]) || !(|data[31:15]));
         end
         SZ_WORD: err = |addr_lo;
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/store_narrower.sv
// rtl/store_narrower.sv - narrows 32-bit stores onto a 16-bit handshaked write port
// Purpose: accepts byte/half/word stores, emits one or two little-endian beats.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   req_valid_i/req_ready_o    store request handshake (ready only in IDLE)
//   addr_i, data_i, size_i     store byte address, right-justified data, size
//   mem_valid_o/mem_ready_i    write beat handshake
//   mem_addr_o, mem_data_o     even-aligned beat address, beat data
//   mem_be_o                   byte enables, bit0 = low byte
//   done_o, err_o, ovf_o       completion, rejection and truncation pulses
module store_narrower
   import store_narrower_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter bit DUP_BYTE   = 1'b1
)
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]           data_i,
   input  logic [1:0]            size_i,
   output logic                  mem_valid_o,
   input  logic                  mem_ready_i,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [MEM_WIDTH-1:0]  mem_data_o,
   output logic [1:0]            mem_be_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic                  ovf_o
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           data_q;
   logic [1:0]            size_q;
   logic                  err_q, ovf_q;
   logic                  chk_err, chk_ovf;
   logic                  accept;

   narrow_check u_check (
      .size    (size_i),
      .addr_lo (addr_i[1:0]),
      .data    (data_i),
      .err     (chk_err),
      .ovf     (chk_ovf)
   );

   assign accept = req_valid_i && req_ready_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         size_q  <= '0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q <= addr_i;
            data_q <= data_i;
            size_q <= size_i;
            err_q  <= chk_err;
            // A rejected store writes nothing, so nothing was truncated.
            ovf_q  <= chk_ovf && !chk_err;
         end
      end
   end

   // Outputs decode only registered state, so mem_ready_i never reaches mem_valid_o.
   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      mem_valid_o = 1'b0;
      mem_addr_o  = '0;
      mem_data_o  = '0;
      mem_be_o    = 2'b00;
      done_o      = 1'b0;
      err_o       = 1'b0;
      ovf_o       = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            // Rejections pass through FIN so done/err pulse the cycle after accept.
            if (accept) state_d = chk_err ? FIN : BEAT_LO;
         end
         BEAT_LO: begin
            mem_valid_o = 1'b1;
            mem_addr_o  = {addr_q[ADDR_WIDTH-1:1], 1'b0};
            if (size_q == SZ_BYTE) begin
               mem_be_o = addr_q[0] ? 2'b10 : 2'b01;
               if (DUP_BYTE)
                  mem_data_o = {data_q[7:0], data_q[7:0]};
               else
                  mem_data_o = addr_q[0] ? {data_q[7:0], 8'h00} : {8'h00, data_q[7:0]};
            end else begin
               mem_be_o   = 2'b11;
               mem_data_o = data_q[15:0];
            end
            if (mem_ready_i) state_d = (size_q == SZ_WORD) ? BEAT_HI : FIN;
         end
         BEAT_HI: begin
            mem_valid_o = 1'b1;
            mem_addr_o  = addr_q + ADDR_WIDTH'(2);
            mem_data_o  = data_q[31:16];
            mem_be_o    = 2'b11;
            if (mem_ready_i) state_d = FIN;
         end
         FIN: begin
            done_o  = 1'b1;
            err_o   = err_q;
            ovf_o   = ovf_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_store_narrower.sv
// tb/tb_store_narrower.sv - self-checking bench for store_narrower
module tb_store_narrower;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic [31:0] data;
   logic [1:0]  size;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [15:0] mem_data;
   logic [1:0]  mem_be;
   logic        done;
   logic        err;
   logic        ovf;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   store_narrower #(.ADDR_WIDTH(32), .DUP_BYTE(1'b1)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .addr_i      (addr),
      .data_i      (data),
      .size_i      (size),
      .mem_valid_o (mem_valid),
      .mem_ready_i (mem_ready),
      .mem_addr_o  (mem_addr),
      .mem_data_o  (mem_data),
      .mem_be_o    (mem_be),
      .done_o      (done),
      .err_o       (err),
      .ovf_o       (ovf)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One store driven from IDLE through done; expectations come from plain arithmetic.
   task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                            input int stall_pct, input int lead_stall);
      int          nbytes, nb, k, stalls, sd;
      logic        e_err, e_ovf, finished;
      logic [31:0] e_addr [2];
      logic [15:0] e_data [2];
      logic [1:0]  e_be   [2];
      int          lead;

      nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
      e_err  = (nbytes == 0) || ((a % nbytes) != 0);
      sd     = $signed(d);
      e_ovf  = 1'b0;
      if (!e_err && nbytes == 1) e_ovf = (sd < -128) || (sd > 127);
      if (!e_err && nbytes == 2) e_ovf = (sd < -32768) || (sd > 32767);
      nb = e_err ? 0 : (nbytes == 4 ? 2 : 1);
      e_addr[0] = a - (a % 2);
      e_addr[1] = a + 32'd2;
      e_data[0] = (nbytes == 1) ? 16'((d % 256) * 257) : 16'(d % 65536);
      e_data[1] = 16'(d / 65536);
      e_be[0]   = (nbytes == 1) ? ((a % 2 == 1) ? 2'b10 : 2'b01) : 2'b11;
      e_be[1]   = 2'b11;

      @(negedge clk);
      chk("req_ready_idle", req_ready, 1'b1);
      req_valid = 1'b1;
      addr = a;
      data = d;
      size = sz;
      mem_ready = 1'b1;
      k = 0;
      stalls = 0;
      lead = lead_stall;
      finished = 1'b0;
      for (int c = 1; c <= 300 && !finished; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         addr = $urandom;
         data = $urandom;
         size = 2'($urandom_range(3));
         chk("req_ready_busy", req_ready, 1'b0);
         chk("mem_valid", mem_valid, k < nb);
         chk("done", done, k == nb);
         if (mem_valid && k < nb) begin
            chk("beat_addr", mem_addr, e_addr[k]);
            chk("beat_data", mem_data, e_data[k]);
            chk("beat_be", mem_be, e_be[k]);
         end
         if (k == nb) begin
            chk("err_at_done", err, e_err);
            chk("ovf_at_done", ovf, e_ovf);
            chk("latency", c, nb + 1 + stalls);
            finished = 1'b1;
         end else begin
            chk("err_quiet", err, 1'b0);
            chk("ovf_quiet", ovf, 1'b0);
         end
         if (mem_valid) begin
            if (k == 0 && lead > 0) begin
               mem_ready = 1'b0;
               lead--;
            end else begin
               mem_ready = ($urandom_range(99) >= stall_pct);
            end
            if (mem_ready) k++;
            else stalls++;
         end else begin
            mem_ready = 1'($urandom_range(1));
         end
      end
      if (!finished) chk("timeout", 1'b0, 1'b1);
      @(negedge clk);
      chk("req_ready_after", req_ready, 1'b1);
      chk("done_single_pulse", done, 1'b0);
   endtask

   initial begin
      logic [31:0] ra, rd;
      logic [1:0]  rs;
      rst = 1'b1;
      req_valid = 1'b0;
      addr = '0;
      data = '0;
      size = '0;
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_mem_valid", mem_valid, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_data", mem_data, 16'h0);
      chk("rst_mem_be", mem_be, 2'b00);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      rst = 1'b0;

      run_store(32'h0000_1001, 32'h0000_0080, 2'b00, 0, 0);
      run_store(32'h0000_2002, 32'hFFFF_8001, 2'b01, 0, 0);
      run_store(32'h0000_3000, 32'hDEAD_BEEF, 2'b10, 0, 3);
      run_store(32'h0000_4002, 32'h1234_5678, 2'b10, 0, 0);
      run_store(32'h0000_4001, 32'h0000_0001, 2'b01, 0, 0);
      run_store(32'h0000_4000, 32'h0000_0001, 2'b11, 0, 0);
      run_store(32'hFFFF_FFFC, 32'hCAFE_F00D, 2'b10, 0, 0);
      run_store(32'hFFFF_FFFE, 32'hCAFE_F00D, 2'b10, 0, 0);
      run_store(32'h0000_0010, 32'hFFFF_FF80, 2'b00, 0, 0);
      run_store(32'h0000_0010, 32'h0000_7FFF, 2'b01, 0, 0);

      // Reset during a stalled high beat aborts the store without done.
      @(negedge clk);
      req_valid = 1'b1;
      addr = 32'h0000_5000;
      data = 32'h1111_2222;
      size = 2'b10;
      mem_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_lo_addr", mem_addr, 32'h0000_5000);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      chk("abort_hi_valid", mem_valid, 1'b1);
      chk("abort_hi_addr", mem_addr, 32'h0000_5002);
      @(negedge clk);
      chk("abort_hi_stalled", mem_valid, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_mem_valid", mem_valid, 1'b0);
      chk("abort_req_ready", req_ready, 1'b1);
      chk("abort_done", done, 1'b0);
      @(negedge clk);
      chk("abort_done_late", done, 1'b0);
      run_store(32'h0000_6003, 32'h0000_0042, 2'b00, 0, 0);

      for (int i = 0; i < 150; i++) begin
         ra = $urandom;
         if ($urandom_range(1) == 0) ra[1:0] = 2'b00;
         case ($urandom_range(2))
            0: rd = $urandom;
            1: rd = 32'($urandom_range(600)) - 32'd300;
            default: rd = 32'($urandom_range(80000)) - 32'd40000;
         endcase
         rs = 2'($urandom_range(3));
         run_store(ra, rd, rs, 30, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
